// File: rtl/ball_pkg.sv
// Shared codes for the HSV ball colour classifier and its scan sequencer:
// colour codes, classifier modes, sequencer state encoding and run record.
package ball_pkg;

   localparam logic [3:0] COLOR_VOID   = 4'h1;
   localparam logic [3:0] COLOR_RED    = 4'h3;
   localparam logic [3:0] COLOR_BLUE   = 4'h5;
   localparam logic [3:0] COLOR_YELLOW = 4'h7;
   localparam logic [3:0] COLOR_BLACK  = 4'hC;

   localparam logic [1:0] MODE_IDLE          = 2'd0;
   localparam logic [1:0] MODE_FIRSTLINE     = 2'd1;
   localparam logic [1:0] MODE_LINE_SAMPLING = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WAIT_FRAME, ST_WAIT_LINE, ST_ACTIVE, ST_DRAIN, ST_REPORT
   } scan_state_t;

   typedef struct packed {
      logic [3:0] color;
      logic [9:0] left;
      logic [9:0] right;
   } run_t;

   function automatic logic is_ball(input logic [3:0] c);
      return (c == COLOR_RED) || (c == COLOR_BLUE) || (c == COLOR_YELLOW);
   endfunction

endpackage

// File: rtl/ball_run_tracker.sv
// Groups per-pixel colour codes of one line into runs and keeps the longest;
// BLACK bridges gaps inside a run, VOID or a new ball colour closes it.
module ball_run_tracker
   import ball_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       class_valid,
   input  logic [3:0] class_color,
   output logic       run_found,
   output logic [3:0] run_color,
   output logic [9:0] run_left,
   output logic [9:0] run_right
);

   run_t       cur, best, sel;
   logic       cur_on, best_on, cur_longer;
   logic [9:0] idx;

   function automatic logic [10:0] run_len(input run_t r);
      return {1'b0, r.right} - {1'b0, r.left} + 11'd1;
   endfunction

   // strict compare: an equal-length later run never displaces an earlier one
   assign cur_longer = cur_on && (!best_on || (run_len(cur) > run_len(best)));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cur     <= '0;
         best    <= '0;
         cur_on  <= 1'b0;
         best_on <= 1'b0;
         idx     <= '0;
      end else if (class_valid) begin
         if (idx != 10'h3FF) idx <= idx + 10'd1;
         if (is_ball(class_color) && cur_on && (class_color == cur.color)) begin
            cur.right <= idx;
         end else if (class_color == COLOR_BLACK) begin
            if (cur_on) cur.right <= idx;
         end else begin
            if (cur_longer) begin
               best    <= cur;
               best_on <= 1'b1;
            end
            cur_on <= is_ball(class_color);
            cur    <= '{color: class_color, left: idx, right: idx};
         end
      end
   end

   always_comb begin
      sel = best;
      if (cur_longer) sel = cur;
   end

   assign run_found = cur_longer || best_on;
   assign run_color = sel.color;
   assign run_left  = sel.left;
   assign run_right = sel.right;

endmodule

// File: rtl/ball_scan_ctrl.sv
// Line/pixel sequencer for the ball colour classifier: strobes sampled pixels,
// drains outstanding classifications and reports the longest run per line.
module ball_scan_ctrl
   import ball_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int FIRST_LINE = 8,
   parameter int LINE_STEP  = 4,
   parameter int MIN_RUN    = 4,
   parameter int DRAIN_MAX  = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       frame_start,
   input  logic       line_start,
   input  logic       pix_valid,
   input  logic       class_valid,
   input  logic [3:0] class_color,
   output logic [1:0] mode,
   output logic       write,
   output logic [9:0] horiz_count,
   output logic [9:0] vert_count,
   output logic       busy,
   output logic       result_valid,
   output logic [3:0] result_color,
   output logic [9:0] result_line,
   output logic [9:0] result_left,
   output logic [9:0] result_right
);

   scan_state_t state, state_nxt;
   logic        first_pend, pix_take, cls_take, last_pix, trk_clear, run_found;
   logic [9:0]  line_nxt, scan_line, pix_cnt, run_left, run_right;
   logic [3:0]  outstanding, drain_cnt, run_color;
   logic [10:0] run_len;

   function automatic logic [1:0] line_mode(input logic [9:0] v);
      if (int'(v) == FIRST_LINE) return MODE_FIRSTLINE;
      if ((int'(v) > FIRST_LINE) && (((int'(v) - FIRST_LINE) % LINE_STEP) == 0))
         return MODE_LINE_SAMPLING;
      return MODE_IDLE;
   endfunction

   // the first line_start after a lone frame_start is line 0, not line 1
   assign line_nxt  = first_pend ? 10'd0 : ((vert_count == 10'h3FF) ? vert_count : vert_count + 10'd1);
   assign pix_take  = (state == ST_ACTIVE) && pix_valid && !line_start && !frame_start;
   assign last_pix  = pix_take && (pix_cnt == 10'(H_ACTIVE - 1));
   assign cls_take  = class_valid && ((state == ST_ACTIVE) || (state == ST_DRAIN));
   assign trk_clear = (state == ST_WAIT_LINE) && (state_nxt == ST_ACTIVE);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:       if (enable) state_nxt = ST_WAIT_FRAME;
         ST_WAIT_FRAME: if (frame_start) state_nxt = ST_WAIT_LINE;
                        else if (!enable) state_nxt = ST_IDLE;
         ST_WAIT_LINE:  if (frame_start) state_nxt = ST_WAIT_LINE;
                        else if (!enable) state_nxt = ST_IDLE;
                        else if (int'(vert_count) >= V_ACTIVE) state_nxt = ST_WAIT_FRAME;
                        else if (line_start && (line_mode(line_nxt) != MODE_IDLE) &&
                                 (int'(line_nxt) < V_ACTIVE)) state_nxt = ST_ACTIVE;
         ST_ACTIVE:     if (frame_start) state_nxt = ST_WAIT_LINE;
                        else if (line_start || last_pix) state_nxt = ST_DRAIN;
         ST_DRAIN:      if (frame_start) state_nxt = ST_WAIT_LINE;
                        else if (((outstanding == 4'd0) && !write) ||
                                 (drain_cnt == 4'(DRAIN_MAX - 1))) state_nxt = ST_REPORT;
         ST_REPORT:     state_nxt = ST_WAIT_LINE;
         default:       state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vert_count <= '0;
         first_pend <= 1'b0;
         scan_line  <= '0;
      end else begin
         if ((state != ST_IDLE) && frame_start) begin
            vert_count <= '0;
            first_pend <= !line_start;
         end else if (line_start && (state != ST_IDLE) && (state != ST_WAIT_FRAME)) begin
            vert_count <= line_nxt;
            first_pend <= 1'b0;
         end
         if (trk_clear) scan_line <= line_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         write       <= 1'b0;
         horiz_count <= '0;
         pix_cnt     <= '0;
         drain_cnt   <= '0;
         outstanding <= '0;
      end else begin
         write <= pix_take;
         if (pix_take) horiz_count <= pix_cnt;
         if (trk_clear) pix_cnt <= '0;
         else if (pix_take && (pix_cnt != 10'(H_ACTIVE - 1))) pix_cnt <= pix_cnt + 10'd1;
         drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 4'd1 : 4'd0;
         if ((state == ST_REPORT) || trk_clear) outstanding <= '0;
         else if (write && !cls_take && (outstanding != 4'hF)) outstanding <= outstanding + 4'd1;
         else if (!write && cls_take && (outstanding != 4'h0)) outstanding <= outstanding - 4'd1;
      end
   end

   ball_run_tracker u_trk (
      .clk         (clk),
      .rst         (rst),
      .clear       (trk_clear),
      .class_valid (cls_take),
      .class_color (class_color),
      .run_found   (run_found),
      .run_color   (run_color),
      .run_left    (run_left),
      .run_right   (run_right)
   );

   assign run_len      = {1'b0, run_right} - {1'b0, run_left} + 11'd1;
   assign result_valid = (state == ST_REPORT) && run_found && (run_len >= 11'(MIN_RUN));
   assign result_color = result_valid ? run_color : 4'd0;
   assign result_line  = result_valid ? scan_line : 10'd0;
   assign result_left  = result_valid ? run_left  : 10'd0;
   assign result_right = result_valid ? run_right : 10'd0;
   assign busy         = (state != ST_IDLE);
   assign mode         = ((state == ST_ACTIVE) || (state == ST_DRAIN)) ? line_mode(vert_count) : MODE_IDLE;

endmodule

// File: tb/tb_ball_scan_ctrl.sv
// Bench for ball_scan_ctrl: a behavioural classifier answers write strobes,
// per-line expectations go to a scoreboard checked on result_valid.
module tb_ball_scan_ctrl;
   import ball_pkg::*;

   logic       clk = 1'b0;
   logic       rst, enable, frame_start, line_start, pix_valid, class_valid;
   logic [3:0] class_color;
   logic [1:0] mode;
   logic       write, busy, result_valid;
   logic [9:0] horiz_count, vert_count, result_line, result_left, result_right;
   logic [3:0] result_color;

   ball_scan_ctrl dut (
      .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
      .line_start(line_start), .pix_valid(pix_valid), .class_valid(class_valid),
      .class_color(class_color), .mode(mode), .write(write), .horiz_count(horiz_count),
      .vert_count(vert_count), .busy(busy), .result_valid(result_valid),
      .result_color(result_color), .result_line(result_line),
      .result_left(result_left), .result_right(result_right)
   );

   always #5 clk = ~clk;

   typedef struct { logic [3:0] color; int line; int left; int right; int cyc; } exp_t;
   typedef struct packed { logic [3:0] c; logic [9:0] lo; logic [9:0] hi; } seg_t;
   typedef struct {
      int line; int npix; seg_t [2:0] seg;
      logic has; logic [3:0] color; int left; int right;
   } vec_t;

   int         total = 0, bad = 0, exp_hc = 0, nwrites = 0, cyc = 0;
   logic       hold = 1'b0;
   logic [3:0] colors [0:1023];
   logic [3:0] cq [$];
   exp_t       sbq [$];
   exp_t       em;
   vec_t       vec [0:6];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(string name, int got, int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   function automatic int exp_mode(int v);
      if (v == 8) return 1;
      if (v > 8 && ((v - 8) % 4) == 0) return 2;
      return 0;
   endfunction

   function automatic seg_t mkseg(logic [3:0] c, int lo, int hi);
      seg_t s;
      s.c = c; s.lo = 10'(lo); s.hi = 10'(hi);
      return s;
   endfunction

   function automatic vec_t mkvec(int line, int npix, seg_t s0, seg_t s1, seg_t s2,
                                  logic has, logic [3:0] color, int left, int right);
      vec_t v;
      v.line = line; v.npix = npix; v.seg[0] = s0; v.seg[1] = s1; v.seg[2] = s2;
      v.has = has; v.color = color; v.left = left; v.right = right;
      return v;
   endfunction

   task automatic paint(logic [3:0] c, int lo, int hi);
      for (int p = lo; p <= hi; p++) colors[p] = c;
   endtask

   task automatic clear_colors();
      for (int p = 0; p < 1024; p++) colors[p] = COLOR_VOID;
   endtask

   task automatic push_exp(logic [3:0] c, int line, int l, int r, int cy);
      exp_t e;
      e.color = c; e.line = line; e.left = l; e.right = r; e.cyc = cy;
      sbq.push_back(e);
   endtask

   task automatic pulse_line();
      line_start = 1'b1; tick(); line_start = 1'b0;
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1; tick(); frame_start = 1'b0;
   endtask

   task automatic pixels(int n);
      for (int i = 0; i < n; i++) begin pix_valid = 1'b1; tick(); end
      pix_valid = 1'b0;
   endtask

   task automatic do_line(int v, int npix);
      int w0, wexp;
      exp_hc = 0;
      w0 = nwrites;
      pulse_line();
      chk("vert_count", vert_count, v);
      chk("mode", mode, exp_mode(v));
      pixels(npix);
      repeat (3) tick();
      wexp = (exp_mode(v) != 0) ? ((npix < 640) ? npix : 640) : 0;
      chk("write_count", nwrites - w0, wexp);
   endtask

   // classifier model: remember the code for each strobed pixel, answer later
   always @(negedge clk) begin
      if (!rst && write) begin
         total++;
         if (int'(horiz_count) != exp_hc) begin
            bad++;
            $display("FAIL horiz_count: got %0d want %0d", horiz_count, exp_hc);
         end
         exp_hc++;
         nwrites++;
         cq.push_back(colors[horiz_count]);
      end
   end

   initial begin
      class_valid = 1'b0;
      class_color = COLOR_VOID;
      forever begin
         tick();
         if (!hold && cq.size() > 0) begin
            class_valid = 1'b1;
            class_color = cq.pop_front();
         end else begin
            class_valid = 1'b0;
            class_color = COLOR_VOID;
         end
      end
   end

   always @(negedge clk) begin
      if (result_valid) begin
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_result: got color=%0h line=%0d left=%0d right=%0d want no pulse",
                     result_color, result_line, result_left, result_right);
         end else begin
            em = sbq.pop_front();
            if (result_color != em.color || int'(result_line) != em.line ||
                int'(result_left) != em.left || int'(result_right) != em.right ||
                (em.cyc >= 0 && cyc != em.cyc)) begin
               bad++;
               $display("FAIL result: got color=%0h line=%0d left=%0d right=%0d cyc=%0d want color=%0h line=%0d left=%0d right=%0d cyc=%0d",
                        result_color, result_line, result_left, result_right, cyc,
                        em.color, em.line, em.left, em.right, em.cyc);
            end
         end
      end
   end

   initial begin
      int vi, c;
      vec[0] = mkvec(8,  160, mkseg(COLOR_RED, 100, 139), mkseg(COLOR_VOID, 1, 0), mkseg(COLOR_VOID, 1, 0), 1'b1, COLOR_RED, 100, 139);
      vec[1] = mkvec(12, 230, mkseg(COLOR_BLUE, 200, 209), mkseg(COLOR_BLACK, 210, 211), mkseg(COLOR_BLUE, 212, 219), 1'b1, COLOR_BLUE, 200, 219);
      vec[2] = mkvec(16, 20,  mkseg(COLOR_RED, 10, 12), mkseg(COLOR_VOID, 1, 0), mkseg(COLOR_VOID, 1, 0), 1'b0, COLOR_VOID, 0, 0);
      vec[3] = mkvec(20, 330, mkseg(COLOR_YELLOW, 50, 69), mkseg(COLOR_RED, 300, 319), mkseg(COLOR_VOID, 1, 0), 1'b1, COLOR_YELLOW, 50, 69);
      vec[4] = mkvec(24, 50,  mkseg(COLOR_RED, 5, 14), mkseg(COLOR_BLUE, 15, 40), mkseg(COLOR_VOID, 1, 0), 1'b1, COLOR_BLUE, 15, 40);
      vec[5] = mkvec(28, 645, mkseg(COLOR_YELLOW, 600, 639), mkseg(COLOR_VOID, 1, 0), mkseg(COLOR_VOID, 1, 0), 1'b1, COLOR_YELLOW, 600, 639);
      vec[6] = mkvec(32, 10,  mkseg(COLOR_BLUE, 0, 3), mkseg(COLOR_VOID, 1, 0), mkseg(COLOR_VOID, 1, 0), 1'b1, COLOR_BLUE, 0, 3);

      clear_colors();
      rst = 1'b1; enable = 1'b0; frame_start = 1'b0; line_start = 1'b0; pix_valid = 1'b0;
      repeat (3) tick();
      chk("rst_mode", mode, 0);
      chk("rst_write", write, 0);
      chk("rst_horiz", horiz_count, 0);
      chk("rst_vert", vert_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_result_color", result_color, 0);
      chk("rst_result_line", result_line, 0);
      chk("rst_result_left", result_left, 0);
      chk("rst_result_right", result_right, 0);
      rst = 1'b0;
      tick();

      // table frame: one vector per sampled line
      enable = 1'b1;
      repeat (2) tick();
      chk("busy_enabled", busy, 1);
      pulse_frame();
      vi = 0;
      for (int v = 0; v <= 33; v++) begin
         if (vi < 7 && vec[vi].line == v) begin
            clear_colors();
            for (int s = 0; s < 3; s++) paint(vec[vi].seg[s].c, int'(vec[vi].seg[s].lo), int'(vec[vi].seg[s].hi));
            if (vec[vi].has) push_exp(vec[vi].color, v, vec[vi].left, vec[vi].right, -1);
            do_line(v, vec[vi].npix);
            vi++;
         end else begin
            do_line(v, 2);
         end
      end

      // frame_start together with line_start: that line is line 0
      frame_start = 1'b1; line_start = 1'b1; tick(); frame_start = 1'b0; line_start = 1'b0;
      chk("both_vert", vert_count, 0);
      for (int v = 1; v <= 11; v++) do_line(v, 2);

      // frame_start in the middle of sampled line 12 aborts it
      clear_colors(); paint(COLOR_RED, 0, 30);
      exp_hc = 0;
      pulse_line();
      chk("abort_vert_pre", vert_count, 12);
      chk("abort_mode_pre", mode, 2);
      pixels(20);
      pulse_frame();
      chk("abort_vert", vert_count, 0);
      chk("abort_busy", busy, 1);
      chk("abort_mode", mode, 0);
      repeat (4) tick();
      for (int v = 0; v <= 7; v++) do_line(v, 2);
      clear_colors(); paint(COLOR_RED, 20, 59);
      push_exp(COLOR_RED, 8, 20, 59, -1);
      do_line(8, 70);
      for (int v = 9; v <= 11; v++) do_line(v, 2);

      // classifier stalls at line end: drain times out, late codes discarded
      clear_colors(); paint(COLOR_RED, 0, 39);
      exp_hc = 0;
      pulse_line();
      chk("drain_vert", vert_count, 12);
      pixels(20);
      repeat (4) tick();
      hold = 1'b1;
      pixels(20);
      line_start = 1'b1;
      c = cyc;
      push_exp(COLOR_RED, 12, 0, 19, c + 8);
      tick();
      line_start = 1'b0;
      chk("drain_vert_next", vert_count, 13);
      repeat (12) tick();
      hold = 1'b0;
      repeat (30) tick();
      do_line(14, 2);
      do_line(15, 2);
      clear_colors(); paint(COLOR_YELLOW, 0, 9);
      push_exp(COLOR_YELLOW, 16, 0, 9, -1);
      do_line(16, 12);
      for (int v = 17; v <= 19; v++) do_line(v, 2);

      // enable dropped mid-line: line still reports, then idle
      clear_colors(); paint(COLOR_RED, 0, 9);
      push_exp(COLOR_RED, 20, 0, 9, -1);
      exp_hc = 0;
      pulse_line();
      chk("endrop_vert", vert_count, 20);
      pixels(12);
      enable = 1'b0;
      repeat (3) tick();
      pulse_line();
      repeat (20) tick();
      chk("endrop_busy", busy, 0);
      chk("endrop_mode", mode, 0);

      // reset in the middle of a sampled line
      enable = 1'b1;
      repeat (2) tick();
      pulse_frame();
      for (int v = 0; v <= 7; v++) do_line(v, 2);
      clear_colors(); paint(COLOR_RED, 0, 39);
      exp_hc = 0;
      pulse_line();
      chk("midrst_mode_pre", mode, 1);
      pixels(20);
      rst = 1'b1;
      tick();
      chk("midrst_busy", busy, 0);
      chk("midrst_vert", vert_count, 0);
      chk("midrst_mode", mode, 0);
      chk("midrst_write", write, 0);
      chk("midrst_horiz", horiz_count, 0);
      chk("midrst_result_valid", result_valid, 0);
      rst = 1'b0;
      enable = 1'b0;
      repeat (30) tick();

      chk("pending_results", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
